sdram_device_model: RTL

- Synthesizable responder for the single-chip 16-bit SDR SDRAM command bus that our SDRAM controllers drive.
- Decodes CS/RAS/CAS/WE commands and keeps per-bank row state. Serves reads with the programmed CAS latency from internal block RAM and applies byte-masked writes.
- Flags protocol and timing violations in sticky error bits.
- Used as an on-FPGA loopback target and as the DUT-side memory in controller benches.

---
 rtl/sdram_pkg.sv | 51 +++++
 rtl/sdram_device_model_if.sv | 35 +++
 rtl/sdram_bank_fsm.sv | 82 ++++++++
 rtl/sdram_device_model.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDR SDRAM device model.
// Command codes, mode-register fields, error bits, bank states.
package sdram_pkg;

  localparam logic [3:0] CMD_LMR = 4'b0000;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  localparam int MR_BL_LSB = 0;
  localparam int MR_BL_MSB = 2;
  localparam int MR_CL_LSB = 4;
  localparam int MR_CL_MSB = 6;
  localparam int MR_OP_LSB = 7;
  localparam int MR_OP_MSB = 8;
  localparam int A_AP      = 10;

  localparam logic [2:0] MR_CL2 = 3'd2;
  localparam logic [2:0] MR_CL3 = 3'd3;

  localparam int ERR_UNINIT = 0;
  localparam int ERR_CLOSED = 1;
  localparam int ERR_ACT    = 2;
  localparam int ERR_TRCD   = 3;
  localparam int ERR_TRFC   = 4;
  localparam int ERR_OPEN   = 5;
  localparam int ERR_MODE   = 6;
  localparam int ERR_BUS    = 7;

  typedef enum logic [1:0] {
    BANK_IDLE,
    BANK_OPENING,
    BANK_OPEN,
    BANK_PRECHARGING
  } bank_state_t;

  function automatic logic mode_legal(
    input logic [12:0] a
  );
    logic [2:0] cl;
    cl = a[MR_CL_MSB:MR_CL_LSB];
    return a[MR_BL_MSB:MR_BL_LSB] == 3'd0
        && (cl == MR_CL2 || cl == MR_CL3)
        && a[MR_OP_MSB:MR_OP_LSB] == 2'd0;
  endfunction

endpackage

// File: rtl/sdram_device_model_if.sv
// SDRAM command bus plus model status.
// master = controller side, slave = device model.
interface sdram_device_model_if;
  logic        sdram_ncs;
  logic        sdram_nras;
  logic        sdram_ncas;
  logic        sdram_nwe;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_a;
  logic        sdram_dqml;
  logic        sdram_dqmh;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        init_done;
  logic [1:0]  cas_lat;
  logic [15:0] refresh_cnt;
  logic [7:0]  err;

  modport master (
    output sdram_ncs, sdram_nras, sdram_ncas,
    output sdram_nwe, sdram_ba, sdram_a,
    output sdram_dqml, sdram_dqmh, dq_in,
    input  dq_out, dq_oe, init_done,
    input  cas_lat, refresh_cnt, err
  );

  modport slave (
    input  sdram_ncs, sdram_nras, sdram_ncas,
    input  sdram_nwe, sdram_ba, sdram_a,
    input  sdram_dqml, sdram_dqmh, dq_in,
    output dq_out, dq_oe, init_done,
    output cas_lat, refresh_cnt, err
  );
endinterface

// File: rtl/sdram_bank_fsm.sv
// One SDRAM bank: open row, state and tRCD/tRP/tWR timer.
// Strobes arrive pre-qualified by the command decoder.
module sdram_bank_fsm
  import sdram_pkg::*;
#(
  parameter int TRCD = 2,
  parameter int TRP  = 2,
  parameter int TWR  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        act_i,
  input  logic        rw_i,
  input  logic        auto_pre_i,
  input  logic        pre_i,
  input  logic        is_write_i,
  input  logic [12:0] row_i,
  output bank_state_t state_o,
  output logic [12:0] row_o
);

  localparam logic [3:0] TRCD_LD = 4'(TRCD - 1);
  localparam logic [3:0] TRP_LD  = 4'(TRP - 1);
  localparam logic [3:0] TWR_LD  = 4'(TRP + TWR - 1);

  bank_state_t state_q;
  logic [3:0]  timer_q;
  logic [12:0] row_q;

  // Timer hits 0 on the same edge the state advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BANK_IDLE;
      timer_q <= '0;
      row_q   <= '0;
    end else begin
      unique case (state_q)
        BANK_IDLE: begin
          if (act_i) begin
            state_q <= BANK_OPENING;
            timer_q <= TRCD_LD;
            row_q   <= row_i;
          end
        end
        BANK_OPENING: begin
          if (pre_i) begin
            state_q <= BANK_PRECHARGING;
            timer_q <= TRP_LD;
          end else if (timer_q <= 4'd1) begin
            state_q <= BANK_OPEN;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q - 4'd1;
          end
        end
        BANK_OPEN: begin
          if (rw_i && auto_pre_i) begin
            state_q <= BANK_PRECHARGING;
            timer_q <= is_write_i ? TWR_LD
                                  : TRP_LD;
          end else if (pre_i) begin
            state_q <= BANK_PRECHARGING;
            timer_q <= TRP_LD;
          end
        end
        BANK_PRECHARGING: begin
          if (timer_q <= 4'd1) begin
            state_q <= BANK_IDLE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q - 4'd1;
          end
        end
        default: state_q <= BANK_IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign row_o   = row_q;

endmodule

// File: rtl/sdram_device_model.sv
// SDR SDRAM responder: command decode, mode/refresh state,
// CL-deep read pipeline and byte-masked memory array.
module sdram_device_model
  import sdram_pkg::*;
#(
  parameter int MEM_AW = 16,
  parameter int TRCD   = 2,
  parameter int TRP    = 2,
  parameter int TWR    = 1,
  parameter int TRFC   = 6
) (
  input logic clk,
  input logic reset,
  sdram_device_model_if.slave bus
);

  localparam logic [3:0] RFC_LD = 4'(TRFC - 1);

  logic [3:0]  cmd;
  logic        is_lmr, is_ref, is_pre;
  logic        is_act, is_wr, is_rd, is_rw;
  logic        live, go, all_idle;
  logic        acc_ok, rd_go, wr_go, act_go;
  logic        mode_ok, cl2, nxt_oe;
  logic [3:0]  bsel;
  logic [7:0]  err_d;
  logic [15:0] nxt_word, w_sel;
  logic [1:0]  m_sel;
  logic [MEM_AW-1:0] idx;
  bank_state_t bst [4];
  bank_state_t sel_st;
  logic [12:0] rows [4];

  logic        init_q;
  logic [1:0]  cl_q;
  logic [15:0] rcnt_q;
  logic [3:0]  rfc_q;
  logic [7:0]  err_q;
  logic        rv_q, dv_q, oe_q;
  logic [15:0] dout_q, ram_q, dd_q;
  logic [1:0]  rmsk_q, dmsk_q;
  logic [15:0] mem_q [0:(1<<MEM_AW)-1];

  assign cmd = {bus.sdram_ncs, bus.sdram_nras,
                bus.sdram_ncas, bus.sdram_nwe};

  always_comb begin
    is_lmr = 1'b0;
    is_ref = 1'b0;
    is_pre = 1'b0;
    is_act = 1'b0;
    is_wr  = 1'b0;
    is_rd  = 1'b0;
    unique case (1'b1)
      cmd == CMD_LMR: is_lmr = 1'b1;
      cmd == CMD_REF: is_ref = 1'b1;
      cmd == CMD_PRE: is_pre = 1'b1;
      cmd == CMD_ACT: is_act = 1'b1;
      cmd == CMD_WR:  is_wr  = 1'b1;
      cmd == CMD_RD:  is_rd  = 1'b1;
      cmd == CMD_BST: ;
      default: ;
    endcase
  end

  always_comb begin
    all_idle = 1'b1;
    for (int b = 0; b < 4; b++)
      if (bst[b] != BANK_IDLE) all_idle = 1'b0;
  end

  assign is_rw   = is_rd || is_wr;
  assign live    = !bus.sdram_ncs && cmd != CMD_NOP;
  assign go      = live && rfc_q == 4'd0;
  assign sel_st  = bst[bus.sdram_ba];
  assign bsel    = 4'b0001 << bus.sdram_ba;
  assign mode_ok = mode_legal(bus.sdram_a);
  assign acc_ok  = go && is_rw && init_q
                && sel_st == BANK_OPEN;
  assign rd_go   = acc_ok && is_rd;
  assign wr_go   = acc_ok && is_wr;
  assign act_go  = go && is_act
                && sel_st == BANK_IDLE;
  assign idx = MEM_AW'({bus.sdram_ba,
                        rows[bus.sdram_ba],
                        bus.sdram_a[8:0]});

  always_comb begin
    err_d = '0;
    err_d[ERR_UNINIT] = go && is_rw && !init_q;
    err_d[ERR_CLOSED] = go && is_rw && init_q
      && (sel_st == BANK_IDLE
       || sel_st == BANK_PRECHARGING);
    err_d[ERR_ACT]  = go && is_act
                   && sel_st != BANK_IDLE;
    err_d[ERR_TRCD] = go && is_rw && init_q
                   && sel_st == BANK_OPENING;
    err_d[ERR_TRFC] = live && rfc_q != 4'd0;
    err_d[ERR_OPEN] = go && (is_ref || is_lmr)
                   && !all_idle;
    err_d[ERR_MODE] = go && is_lmr && all_idle
                   && !mode_ok;
    err_d[ERR_BUS]  = go && is_wr && nxt_oe;
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    sdram_bank_fsm #(
      .TRCD(TRCD),
      .TRP (TRP),
      .TWR (TWR)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .act_i     (act_go && bsel[b]),
      .rw_i      (acc_ok && bsel[b]),
      .auto_pre_i(bus.sdram_a[A_AP]),
      .pre_i     (go && is_pre
                  && (bus.sdram_a[A_AP] || bsel[b])),
      .is_write_i(is_wr),
      .row_i     (bus.sdram_a),
      .state_o   (bst[b]),
      .row_o     (rows[b])
    );
  end

  // CL2 outputs straight from the RAM register, CL3 via one more stage.
  assign cl2      = cl_q == 2'd2;
  assign nxt_oe   = cl2 ? rv_q : dv_q;
  assign w_sel    = cl2 ? ram_q : dd_q;
  assign m_sel    = cl2 ? rmsk_q : dmsk_q;
  assign nxt_word = {m_sel[1] ? 8'h00 : w_sel[15:8],
                     m_sel[0] ? 8'h00 : w_sel[7:0]};

  always_ff @(posedge clk) begin
    if (wr_go && !bus.sdram_dqml)
      mem_q[idx][7:0] <= bus.dq_in[7:0];
    if (wr_go && !bus.sdram_dqmh)
      mem_q[idx][15:8] <= bus.dq_in[15:8];
    ram_q  <= mem_q[idx];
    rmsk_q <= {bus.sdram_dqmh, bus.sdram_dqml};
    dd_q   <= ram_q;
    dmsk_q <= rmsk_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init_q <= 1'b0;
      cl_q   <= 2'd2;
      rcnt_q <= '0;
      rfc_q  <= '0;
      err_q  <= '0;
      rv_q   <= 1'b0;
      dv_q   <= 1'b0;
      oe_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      err_q <= err_q | err_d;
      if (rfc_q != 4'd0) rfc_q <= rfc_q - 4'd1;
      if (go && is_ref && all_idle) begin
        rcnt_q <= rcnt_q + 16'd1;
        rfc_q  <= RFC_LD;
      end
      if (go && is_lmr && all_idle && mode_ok) begin
        cl_q   <= bus.sdram_a[MR_CL_LSB+1:MR_CL_LSB];
        init_q <= 1'b1;
      end
      rv_q   <= rd_go;
      dv_q   <= rv_q;
      oe_q   <= nxt_oe;
      dout_q <= nxt_oe ? nxt_word : 16'h0000;
    end
  end

  assign bus.dq_out      = dout_q;
  assign bus.dq_oe       = oe_q;
  assign bus.init_done   = init_q;
  assign bus.cas_lat     = cl_q;
  assign bus.refresh_cnt = rcnt_q;
  assign bus.err         = err_q;

endmodule
